muldiv_unit: RTL



---
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_unit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// Operand, control and result bundle between the execute-stage controller and muldiv_unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            hiwe;
  logic            lowe;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, a, b, hiwe, lowe, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hiwe, lowe, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO registers.
// Define MULDIV_SIGNED_EN to build signed MULT/DIV; otherwise every op is unsigned.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             isDiv;
  logic [XLEN-1:0]  dReg;
  logic [XLEN-1:0]  accHi;
  logic [XLEN-1:0]  accLo;
  logic [XLEN-1:0]  hiReg;
  logic [XLEN-1:0]  loReg;
  logic             doneReg;

  logic [XLEN:0]    mulSum;
  logic [XLEN:0]    divShift;
  logic [XLEN:0]    divDiff;
  logic [XLEN-1:0]  nextHi;
  logic [XLEN-1:0]  nextLo;
  logic [XLEN-1:0]  resHi;
  logic [XLEN-1:0]  resLo;
  logic [XLEN-1:0]  opA;
  logic [XLEN-1:0]  opB;

  // One iteration: multiply keeps {accHi,accLo} as partial product / multiplier,
  // divide keeps accHi as partial remainder and shifts quotient bits into accLo.
  always_comb begin
    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, dReg} : '0);
    divShift = {accHi, accLo[XLEN-1]};
    divDiff  = divShift - {1'b0, dReg};
    if (isDiv) begin
      nextHi = divDiff[XLEN] ? divShift[XLEN-1:0] : divDiff[XLEN-1:0];
      nextLo = {accLo[XLEN-2:0], ~divDiff[XLEN]};
    end else begin
      nextHi = mulSum[XLEN:1];
      nextLo = {mulSum[0], accLo[XLEN-1:1]};
    end
  end

`ifdef MULDIV_SIGNED_EN
  logic              signA;
  logic              signB;
  logic              negRes;
  logic              negRem;
  logic [2*XLEN-1:0] prodNeg;

  assign signA   = bus.op[0] & bus.a[XLEN-1];
  assign signB   = bus.op[0] & bus.b[XLEN-1];
  assign opA     = signA ? -bus.a : bus.a;
  assign opB     = signB ? -bus.b : bus.b;
  assign prodNeg = -{nextHi, nextLo};

  // Divide by zero leaves the quotient as all ones; remainder sign still restores A.
  always_comb begin
    resHi = nextHi;
    resLo = nextLo;
    if (isDiv) begin
      if (negRes) resLo = -nextLo;
      if (negRem) resHi = -nextHi;
    end else if (negRes) begin
      {resHi, resLo} = prodNeg;
    end
  end
`else
  logic unusedSignSel;

  assign unusedSignSel = bus.op[0];
  assign opA           = bus.a;
  assign opB           = bus.b;
  assign resHi         = nextHi;
  assign resLo         = nextLo;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      isDiv   <= 1'b0;
      dReg    <= '0;
      accHi   <= '0;
      accLo   <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      doneReg <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      negRes  <= 1'b0;
      negRem  <= 1'b0;
`endif
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            isDiv <= bus.op[1];
            dReg  <= bus.op[1] ? opB : opA;
            accHi <= '0;
            accLo <= bus.op[1] ? opA : opB;
            cnt   <= '0;
            state <= RUN;
`ifdef MULDIV_SIGNED_EN
            negRes <= (signA ^ signB) & (~bus.op[1] | (bus.b != '0));
            negRem <= signA & bus.op[1];
`endif
          end else begin
            if (bus.hiwe) hiReg <= bus.wdata;
            if (bus.lowe) loReg <= bus.wdata;
          end
        end
        RUN: begin
          accHi <= nextHi;
          accLo <= nextLo;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN - 1)) begin
            hiReg   <= resHi;
            loReg   <= resLo;
            doneReg <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = doneReg;
  assign bus.hi   = hiReg;
  assign bus.lo   = loReg;

endmodule
